// File: rtl/linear_alloc_sched_pkg.sv
// rtl/linear_alloc_sched_pkg.sv - TauCfg shared sizing constants for the linear allocation scheduler
package TauCfg;
  localparam int N_ICFG         = 4;
  localparam int DBW            = 8;
  localparam int LOCAL_ADDR_BW0 = 10;
  // id/count width must also hold the value N_ICFG itself
  localparam int ICFG_BW        = $clog2(N_ICFG + 1);
endpackage

// File: rtl/linear_alloc_sched_id_fifo.sv
// rtl/linear_alloc_sched_id_fifo.sv - sched_id_fifo: expected retirement id queue
import TauCfg::*;

module sched_id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = ICFG_BW
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/linear_alloc_sched.sv
// rtl/linear_alloc_sched.sv - linear SRAM allocation scheduler; SCHED_ID_CHECK_EN adds in-order retirement id checking
import TauCfg::*;

module linear_alloc_sched #(
  parameter int LBW     = LOCAL_ADDR_BW0,
  parameter int MAX_OUT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_rdy,
  output logic               o_cfg_ack,
  input  logic [ICFG_BW-1:0] i_cfg_num,
  input  logic [LBW-1:0]     i_cfg_linear [N_ICFG],
  input  logic [LBW:0]       i_cfg_size   [N_ICFG],
  input  logic [N_ICFG-1:0]  i_cfg_skip,
  input  logic [DBW-1:0]     i_cfg_padv   [N_ICFG],
  output logic               o_alloc_linear_rdy,
  input  logic               i_alloc_linear_ack,
  output logic [LBW-1:0]     o_linear,
  output logic [ICFG_BW-1:0] o_linear_id,
  output logic [LBW:0]       o_size,
  output logic               o_skip,
  output logic [DBW-1:0]     o_padv,
  input  logic               i_done_linear_rdy,
  output logic               o_done_linear_ack,
  input  logic [ICFG_BW-1:0] i_done_linear_id,
  output logic               o_block_done_rdy,
  input  logic               i_block_done_ack,
  output logic               o_err
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int IW = (N_ICFG > 1) ? $clog2(N_ICFG) : 1;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } Fsm;

  Fsm                 state;
  logic [ICFG_BW-1:0] idx;
  logic [ICFG_BW-1:0] num;
  logic [OW-1:0]      outstanding;
  logic [OW-1:0]      next_out;
  logic               err;
  logic [LBW-1:0]     cfg_linear [N_ICFG];
  logic [LBW:0]       cfg_size   [N_ICFG];
  logic [N_ICFG-1:0]  cfg_skip;
  logic [DBW-1:0]     cfg_padv   [N_ICFG];
  logic [IW-1:0]      idx_sel;
  logic               alloc_fire;
  logic               done_fire;
  logic               id_bad;

  // acks are gated by reset so nothing handshakes while reset is held
  assign o_cfg_ack          = i_rst && (state == IDLE) && i_cfg_rdy;
  assign o_alloc_linear_rdy = (state == ISSUE) && (idx < num) && (outstanding < OW'(MAX_OUT));
  assign o_done_linear_ack  = i_rst && ((state == ISSUE) || (state == DRAIN)) && i_done_linear_rdy;
  assign o_block_done_rdy   = (state == DONE);
  assign o_err              = err;

  assign alloc_fire = o_alloc_linear_rdy && i_alloc_linear_ack;
  assign done_fire  = o_done_linear_ack;

  assign idx_sel     = (idx < ICFG_BW'(N_ICFG)) ? idx[IW-1:0] : '0;
  assign o_linear    = cfg_linear[idx_sel];
  assign o_size      = cfg_size[idx_sel];
  assign o_skip      = cfg_skip[idx_sel];
  assign o_padv      = cfg_padv[idx_sel];
  assign o_linear_id = idx;

  always_comb begin
    next_out = outstanding;
    if (alloc_fire && !done_fire)
      next_out = outstanding + OW'(1);
    else if (!alloc_fire && done_fire && (outstanding != '0))
      next_out = outstanding - OW'(1);
  end

`ifdef SCHED_ID_CHECK_EN
  logic [ICFG_BW-1:0] exp_id;
  logic               fifo_empty;

  sched_id_fifo #(
    .DEPTH (MAX_OUT),
    .W     (ICFG_BW)
  ) u_id_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (alloc_fire),
    .push_data (idx),
    .pop       (done_fire && !fifo_empty),
    .head      (exp_id),
    .empty     (fifo_empty)
  );

  assign id_bad = done_fire && (fifo_empty || (i_done_linear_id != exp_id));
`else
  logic unused_done_id;
  assign unused_done_id = ^i_done_linear_id;
  assign id_bad         = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      idx         <= '0;
      num         <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      cfg_skip    <= '0;
      for (int i = 0; i < N_ICFG; i++) begin
        cfg_linear[i] <= '0;
        cfg_size[i]   <= '0;
        cfg_padv[i]   <= '0;
      end
    end else begin
      if ((((state == IDLE) || (state == DONE)) && i_done_linear_rdy) || id_bad)
        err <= 1'b1;
      outstanding <= next_out;
      if (alloc_fire) idx <= idx + ICFG_BW'(1);
      case (state)
        IDLE: begin
          if (o_cfg_ack) begin
            num      <= i_cfg_num;
            idx      <= '0;
            cfg_skip <= i_cfg_skip;
            for (int i = 0; i < N_ICFG; i++) begin
              cfg_linear[i] <= i_cfg_linear[i];
              cfg_size[i]   <= i_cfg_size[i];
              cfg_padv[i]   <= i_cfg_padv[i];
            end
            state <= (i_cfg_num == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: if (alloc_fire && ((idx + ICFG_BW'(1)) == num)) state <= DRAIN;
        DRAIN: if (next_out == '0) state <= DONE;
        DONE:  if (i_block_done_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_linear_alloc_sched.sv
// tb/tb_linear_alloc_sched.sv - directed vector bench for linear_alloc_sched
import TauCfg::*;

module tb_linear_alloc_sched;
  localparam int LBW = LOCAL_ADDR_BW0;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_cfg_rdy;
  logic               o_cfg_ack;
  logic [ICFG_BW-1:0] i_cfg_num;
  logic [LBW-1:0]     i_cfg_linear [N_ICFG];
  logic [LBW:0]       i_cfg_size   [N_ICFG];
  logic [N_ICFG-1:0]  i_cfg_skip;
  logic [DBW-1:0]     i_cfg_padv   [N_ICFG];
  logic               o_alloc_linear_rdy;
  logic               i_alloc_linear_ack;
  logic [LBW-1:0]     o_linear;
  logic [ICFG_BW-1:0] o_linear_id;
  logic [LBW:0]       o_size;
  logic               o_skip;
  logic [DBW-1:0]     o_padv;
  logic               i_done_linear_rdy;
  logic               o_done_linear_ack;
  logic [ICFG_BW-1:0] i_done_linear_id;
  logic               o_block_done_rdy;
  logic               i_block_done_ack;
  logic               o_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  linear_alloc_sched #(.LBW(LBW), .MAX_OUT(2)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_cfg_rdy          (i_cfg_rdy),
    .o_cfg_ack          (o_cfg_ack),
    .i_cfg_num          (i_cfg_num),
    .i_cfg_linear       (i_cfg_linear),
    .i_cfg_size         (i_cfg_size),
    .i_cfg_skip         (i_cfg_skip),
    .i_cfg_padv         (i_cfg_padv),
    .o_alloc_linear_rdy (o_alloc_linear_rdy),
    .i_alloc_linear_ack (i_alloc_linear_ack),
    .o_linear           (o_linear),
    .o_linear_id        (o_linear_id),
    .o_size             (o_size),
    .o_skip             (o_skip),
    .o_padv             (o_padv),
    .i_done_linear_rdy  (i_done_linear_rdy),
    .o_done_linear_ack  (o_done_linear_ack),
    .i_done_linear_id   (i_done_linear_id),
    .o_block_done_rdy   (o_block_done_rdy),
    .i_block_done_ack   (i_block_done_ack),
    .o_err              (o_err)
  );

  typedef struct {
    int num, cfg_rdy, alloc_ack, done_rdy, done_id, blk_ack;
    int e_cfg_ack, e_alloc_rdy, e_id, e_lin, e_skip, e_done_ack, e_blk_rdy, e_out;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input int num, cfg_rdy, alloc_ack, done_rdy, done_id, blk_ack,
                   input int e_cfg_ack, e_alloc_rdy, e_id, e_lin, e_skip, e_done_ack, e_blk_rdy, e_out);
    vec_t r;
    r.num = num; r.cfg_rdy = cfg_rdy; r.alloc_ack = alloc_ack;
    r.done_rdy = done_rdy; r.done_id = done_id; r.blk_ack = blk_ack;
    r.e_cfg_ack = e_cfg_ack; r.e_alloc_rdy = e_alloc_rdy; r.e_id = e_id; r.e_lin = e_lin;
    r.e_skip = e_skip; r.e_done_ack = e_done_ack; r.e_blk_rdy = e_blk_rdy; r.e_out = e_out;
    vecs.push_back(r);
  endtask

  task automatic check(input string nm, input int row, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0d, expected %0d", nm, row, act, exp_v);
    end
  endtask

  task automatic drive(input int num, cfg_rdy, alloc_ack, done_rdy, done_id, blk_ack);
    i_cfg_num          = ICFG_BW'(num);
    i_cfg_rdy          = cfg_rdy[0];
    i_alloc_linear_ack = alloc_ack[0];
    i_done_linear_rdy  = done_rdy[0];
    i_done_linear_id   = ICFG_BW'(done_id);
    i_block_done_ack   = blk_ack[0];
  endtask

  initial begin
    for (int i = 0; i < N_ICFG; i++) begin
      i_cfg_linear[i] = LBW'(64 * i);
      i_cfg_size[i]   = (LBW + 1)'(16);
      i_cfg_padv[i]   = DBW'(8'hA0 + i);
    end
    i_cfg_skip = 4'b0010;
    i_rst = 1'b0;
    drive(3, 1, 0, 0, 0, 0);

    // num=3: immediate alloc ack, retire two cycles after each alloc
    v(3,1,0,0,0,0, 1,0,0,  0,0,0,0,0);
    v(3,0,1,0,0,0, 0,1,0,  0,0,0,0,0);
    v(3,0,1,0,0,0, 0,1,1, 64,1,0,0,1);
    v(3,0,0,1,0,0, 0,0,0,  0,0,1,0,2);
    v(3,0,1,1,1,0, 0,1,2,128,0,1,0,1);
    v(3,0,0,0,0,0, 0,0,0,  0,0,0,0,1);
    v(3,0,0,1,2,0, 0,0,0,  0,0,1,0,1);
    v(3,0,0,0,0,1, 0,0,0,  0,0,0,1,0);
    v(3,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    // num=0: straight to DONE, rdy held until ack
    v(0,1,0,0,0,0, 1,0,0,  0,0,0,0,0);
    v(0,0,0,0,0,0, 0,0,0,  0,0,0,1,0);
    v(0,0,0,0,0,1, 0,0,0,  0,0,0,1,0);
    v(0,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    // MAX_OUT throttling with retirement withheld
    v(3,1,0,0,0,0, 1,0,0,  0,0,0,0,0);
    v(3,0,1,0,0,0, 0,1,0,  0,0,0,0,0);
    v(3,0,1,0,0,0, 0,1,1, 64,1,0,0,1);
    v(3,0,1,0,0,0, 0,0,0,  0,0,0,0,2);
    v(3,0,1,1,0,0, 0,0,0,  0,0,1,0,2);
    v(3,0,1,0,0,0, 0,1,2,128,0,0,0,1);
    v(3,0,0,1,1,0, 0,0,0,  0,0,1,0,2);
    v(3,0,0,1,2,0, 0,0,0,  0,0,1,0,1);
    v(3,0,0,0,0,1, 0,0,0,  0,0,0,1,0);
    v(3,0,0,0,0,0, 0,0,0,  0,0,0,0,0);
    // skipped id 1 allocated in the same cycle as retirement of id 0
    v(3,1,0,0,0,0, 1,0,0,  0,0,0,0,0);
    v(3,0,1,0,0,0, 0,1,0,  0,0,0,0,0);
    v(3,0,1,1,0,0, 0,1,1, 64,1,1,0,1);
    v(3,0,1,0,0,0, 0,1,2,128,0,0,0,1);
    v(3,0,0,1,1,0, 0,0,0,  0,0,1,0,2);
    v(3,0,0,1,2,0, 0,0,0,  0,0,1,0,1);
    v(3,0,0,0,0,1, 0,0,0,  0,0,0,1,0);
    v(3,0,0,0,0,0, 0,0,0,  0,0,0,0,0);

    @(negedge i_clk);
    #1;
    check("reset cfg_ack", -1, int'(o_cfg_ack), 0);
    check("reset alloc_rdy", -1, int'(o_alloc_linear_rdy), 0);
    check("reset blk_rdy", -1, int'(o_block_done_rdy), 0);
    check("reset err", -1, int'(o_err), 0);
    check("reset outstanding", -1, int'(dut.outstanding), 0);
    @(negedge i_clk);
    i_rst = 1'b1;

    foreach (vecs[r]) begin
      drive(vecs[r].num, vecs[r].cfg_rdy, vecs[r].alloc_ack, vecs[r].done_rdy, vecs[r].done_id, vecs[r].blk_ack);
      #1;
      check("cfg_ack", r, int'(o_cfg_ack), vecs[r].e_cfg_ack);
      check("alloc_rdy", r, int'(o_alloc_linear_rdy), vecs[r].e_alloc_rdy);
      check("done_ack", r, int'(o_done_linear_ack), vecs[r].e_done_ack);
      check("blk_rdy", r, int'(o_block_done_rdy), vecs[r].e_blk_rdy);
      check("outstanding", r, int'(dut.outstanding), vecs[r].e_out);
      if (vecs[r].e_alloc_rdy != 0) begin
        check("linear_id", r, int'(o_linear_id), vecs[r].e_id);
        check("linear", r, int'(o_linear), vecs[r].e_lin);
        check("skip", r, int'(o_skip), vecs[r].e_skip);
        check("size", r, int'(o_size), 16);
        check("padv", r, int'(o_padv), 8'hA0 + vecs[r].e_id);
      end
      @(negedge i_clk);
    end

    // retire request while idle: refused and flagged
    drive(3, 0, 0, 1, 0, 0);
    #1;
    check("idle done_ack", 100, int'(o_done_linear_ack), 0);
    check("err before edge", 100, int'(o_err), 0);
    @(negedge i_clk);
    drive(3, 0, 0, 0, 0, 0);
    #1;
    check("idle err sticky", 101, int'(o_err), 1);
    @(negedge i_clk);
    #1;
    check("err still set", 102, int'(o_err), 1);

    // reset asserted mid-DRAIN
    drive(3, 1, 0, 0, 0, 0); @(negedge i_clk);
    drive(3, 0, 1, 0, 0, 0); @(negedge i_clk);
    drive(3, 0, 1, 1, 0, 0); @(negedge i_clk);
    drive(3, 0, 1, 0, 0, 0); @(negedge i_clk);
    drive(3, 1, 0, 1, 1, 0);
    #1;
    check("drain done_ack", 110, int'(o_done_linear_ack), 1);
    i_rst = 1'b0;
    #1;
    check("rst done_ack", 111, int'(o_done_linear_ack), 0);
    check("rst cfg_ack", 111, int'(o_cfg_ack), 0);
    check("rst alloc_rdy", 111, int'(o_alloc_linear_rdy), 0);
    check("rst blk_rdy", 111, int'(o_block_done_rdy), 0);
    check("rst err", 111, int'(o_err), 0);
    check("rst size", 111, int'(o_size), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    drive(3, 1, 0, 0, 0, 0);
    #1;
    check("post-rst cfg_ack", 112, int'(o_cfg_ack), 1);
    @(negedge i_clk);
    drive(3, 0, 1, 0, 0, 0);
    #1;
    check("post-rst alloc_rdy", 113, int'(o_alloc_linear_rdy), 1);
    check("post-rst linear_id", 113, int'(o_linear_id), 0);
    check("post-rst size", 113, int'(o_size), 16);

`ifdef SCHED_ID_CHECK_EN
    // out-of-order retirement: id 2 offered while id 1 is at the head
    @(negedge i_clk);
    drive(3, 0, 1, 1, 0, 0);
    #1;
    check("idchk in-order ack", 120, int'(o_done_linear_ack), 1);
    @(negedge i_clk);
    drive(3, 0, 0, 1, 2, 0);
    #1;
    check("idchk err before", 121, int'(o_err), 0);
    @(negedge i_clk);
    drive(3, 0, 0, 0, 0, 0);
    #1;
    check("idchk err set", 122, int'(o_err), 1);
`endif

    @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/linear_alloc_sched.md
LINEAR_ALLOC_SCHED -- requirements
Module: linear_alloc_sched

Interface
REQ-001 The block SHALL have parameter LBW, default TauCfg::LOCAL_ADDR_BW0, meaning local SRAM linear address width.
REQ-002 The block SHALL have parameter MAX_OUT, default 2, meaning the maximum number of allocations issued but not yet retired (range 1..7).
REQ-003 Port i_clk, input, 1: clock.
REQ-004 Port i_rst, input, 1: reset, asynchronous, active-low.
REQ-005 Ports i_cfg_rdy (input, 1) and o_cfg_ack (output, 1): block configuration handshake.
REQ-006 Port i_cfg_num, input, ICFG_BW: number of input configs to allocate, 0..N_ICFG.
REQ-007 Ports i_cfg_linear [N_ICFG] (input, LBW), i_cfg_size [N_ICFG] (input, LBW+1), i_cfg_skip (input, N_ICFG) and i_cfg_padv [N_ICFG] (input, DBW): per-config base, length, skip flag and pad value.
REQ-008 Ports o_alloc_linear_rdy (output, 1) and i_alloc_linear_ack (input, 1): handshake toward the SRAM write collector.
REQ-009 Ports o_linear (output, LBW), o_linear_id (output, ICFG_BW), o_size (output, LBW+1), o_skip (output, 1) and o_padv (output, DBW): allocation payload.
REQ-010 Ports i_done_linear_rdy (input, 1), o_done_linear_ack (output, 1) and i_done_linear_id (input, ICFG_BW): retirement from the collector.
REQ-011 Ports o_block_done_rdy (output, 1) and i_block_done_ack (input, 1): block completion handshake.
REQ-012 Port o_err, output, 1: sticky protocol error flag.

Function
REQ-013 The block SHALL implement a one-hot FSM with states IDLE, ISSUE, DRAIN and DONE.
REQ-014 All handshakes SHALL be rdy/ack: rdy is held until ack, a transfer completes in the cycle ack is high, and ack is combinational from rdy and state.
REQ-015 In IDLE, o_cfg_ack SHALL equal i_cfg_rdy, and all cfg inputs SHALL be latched on ack.
REQ-016 On cfg ack, the FSM SHALL go to DONE if i_cfg_num==0, otherwise to ISSUE.
REQ-017 In ISSUE, o_alloc_linear_rdy SHALL be 1 exactly when idx<num and outstanding<MAX_OUT.
REQ-018 The payload SHALL be driven from the latched config indexed by idx, with o_linear_id=idx, and SHALL be stable while rdy is high.
REQ-019 On alloc ack, idx SHALL increment and outstanding SHALL increment.
REQ-020 When the last index is acked, the FSM SHALL move to DRAIN in the next cycle.
REQ-021 o_done_linear_ack SHALL equal i_done_linear_rdy in ISSUE and DRAIN, and SHALL be 0 in IDLE and DONE.
REQ-022 Each done ack SHALL decrement outstanding.
REQ-023 A simultaneous alloc ack and done ack SHALL leave outstanding unchanged.
REQ-024 In DRAIN, the FSM SHALL go to DONE when outstanding is 0, or when it becomes 0 through a done ack in that cycle.
REQ-025 In DONE, o_block_done_rdy SHALL be 1, and i_block_done_ack SHALL return the FSM to IDLE.
REQ-026 Skipped configs (skip=1) SHALL still be allocated and retired in order, because the collector commits them immediately.
REQ-027 outstanding SHALL be $clog2(MAX_OUT+1) bits wide, and idx SHALL be ICFG_BW bits wide.
REQ-028 Neither counter SHALL wrap: an alloc ack at MAX_OUT cannot occur because rdy is low there.
REQ-029 o_err SHALL set on i_done_linear_rdy in IDLE or DONE, and SHALL clear only on reset.

Reset
REQ-030 On i_rst low, the FSM SHALL be IDLE, idx, outstanding and o_err SHALL be 0, all latched cfg SHALL be 0, and all rdy/ack outputs SHALL be 0.
REQ-031 Reset mid-operation SHALL abandon the in-flight block with no further handshakes.

Configuration
REQ-032 With macro SCHED_ID_CHECK_EN defined, the block SHALL keep an expected-id FIFO of depth MAX_OUT, pushed on alloc ack and popped on done ack.
REQ-033 With SCHED_ID_CHECK_EN defined, a done ack whose i_done_linear_id differs from the FIFO head SHALL set o_err.
REQ-034 Without SCHED_ID_CHECK_EN, the FIFO SHALL be absent and i_done_linear_id SHALL be ignored.

Structure
REQ-035 N_ICFG, DBW and LOCAL_ADDR_BW0 SHALL be taken from package TauCfg, and the Fsm enum SHALL be local to the block.
REQ-036 The expected-id FIFO SHALL be sub-module sched_id_fifo, instantiated only under SCHED_ID_CHECK_EN.

Verification
REQ-037 cfg num=3, bases 0/64/128, sizes 16, collector acks at once and retires 2 cycles later -> allocs carry ids 0,1,2 with linear 0,64,128, and block_done_rdy rises after the third retire.
REQ-038 MAX_OUT=2, retire withheld -> rdy drops after two acks, and the third alloc issues the cycle after the first done ack.
REQ-039 num=0 -> DONE the cycle after cfg ack, with no alloc rdy ever.
REQ-040 skip=1 on id 1 with a same-cycle alloc ack and done ack -> outstanding unchanged and payload o_skip=1.
REQ-041 done_linear_rdy in IDLE -> no ack and o_err=1; with SCHED_ID_CHECK_EN, retiring id 2 while id 1 is expected -> o_err=1.
REQ-042 Reset asserted in DRAIN -> all outputs 0 immediately and a new cfg is accepted afterward.
